// File: rtl/bus_wrr_sched_if.sv
// rtl/bus_wrr_sched_if.sv - packet bus bundle between the WRR scheduler and its device FIFOs
interface bus_wrr_sched_if #(
    parameter int DRVRS   = 4,
    parameter int PCKG_SZ = 16
);
    logic [DRVRS-1:0]         pndng;
    logic [DRVRS*PCKG_SZ-1:0] D_pop;
    logic [DRVRS-1:0]         pop;
    logic [DRVRS-1:0]         push;
    logic [PCKG_SZ-1:0]       D_push;
    logic [DRVRS-1:0]         gnt;

    modport master (input pndng, D_pop, output pop, push, D_push, gnt);
    modport slave  (output pndng, D_pop, input pop, push, D_push, gnt);
endinterface

// File: rtl/bus_wrr_sched.sv
// rtl/bus_wrr_sched.sv - weighted round-robin packet bus scheduler (IDLE -> POP -> PUSH)
// Optional per-source push counters under BUS_WRR_SCHED_STATS_EN.
module bus_wrr_sched #(
    parameter int         DRVRS     = 4,
    parameter int         PCKG_SZ   = 16,
    parameter int         WGHT_W    = 3,
    parameter logic [7:0] BROADCAST = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    bus_wrr_sched_if.master          bus,
    input  logic [DRVRS*WGHT_W-1:0]  wght,
    input  logic                     wght_ld,
    output logic                     busy,
    output logic                     err_addr
`ifdef BUS_WRR_SCHED_STATS_EN
    ,
    input  logic                     stat_clr,
    output logic [DRVRS*16-1:0]      stat_cnt
`endif
);
    localparam int IW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

    typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

    state_t             state;
    logic [IW-1:0]      owner;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      next_owner;
    logic [IW-1:0]      cand;
    logic [IW-1:0]      sel;
    logic               found;
    logic               keep;
    logic [WGHT_W-1:0]  credit;
    logic [WGHT_W-1:0]  reload;
    logic [WGHT_W-1:0]  weight [DRVRS];
    logic [PCKG_SZ-1:0] head;
    logic [7:0]         dest;

    // Cyclic search for the next requester, starting just after the RR pointer.
    always_comb begin
        next_owner = owner;
        cand       = '0;
        found      = 1'b0;
        for (int k = 1; k <= DRVRS; k++) begin
            cand = IW'((int'(ptr) + k) % DRVRS);
            if (!found && bus.pndng[cand]) begin
                next_owner = cand;
                found      = 1'b1;
            end
        end
    end

    assign keep   = (credit != '0) && bus.pndng[owner];
    assign sel    = keep ? owner : next_owner;
    assign reload = (weight[next_owner] == '0) ? WGHT_W'(1) : weight[next_owner];
    assign head   = bus.D_pop[owner*PCKG_SZ +: PCKG_SZ];
    assign dest   = head[PCKG_SZ-1 -: 8];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            ptr        <= IW'(DRVRS-1);
            credit     <= '0;
            bus.pop    <= '0;
            bus.push   <= '0;
            bus.gnt    <= '0;
            bus.D_push <= '0;
            err_addr   <= 1'b0;
            busy       <= 1'b0;
            for (int i = 0; i < DRVRS; i++) weight[i] <= WGHT_W'(1);
        end else begin
            // A weight load never touches the live credit; it is seen at the next reload.
            if (wght_ld) begin
                for (int i = 0; i < DRVRS; i++) weight[i] <= wght[i*WGHT_W +: WGHT_W];
            end
            case (state)
                IDLE: begin
                    bus.push <= '0;
                    err_addr <= 1'b0;
                    if (bus.pndng != '0) begin
                        owner   <= sel;
                        bus.gnt <= DRVRS'(1) << sel;
                        bus.pop <= DRVRS'(1) << sel;
                        if (!keep) begin
                            ptr    <= next_owner;
                            credit <= reload;
                        end
                        busy  <= 1'b1;
                        state <= POP;
                    end else begin
                        bus.gnt <= '0;
                        bus.pop <= '0;
                        busy    <= 1'b0;
                    end
                end
                POP: begin
                    bus.pop    <= '0;
                    bus.D_push <= head;
                    if (int'(dest) < DRVRS) begin
                        bus.push <= DRVRS'(1) << dest;
                    end else if (dest == BROADCAST) begin
                        bus.push <= ~(DRVRS'(1) << owner);
                    end else begin
                        bus.push <= '0;
                        err_addr <= 1'b1;
                    end
                    state <= PUSH;
                end
                PUSH: begin
                    bus.push <= '0;
                    bus.gnt  <= '0;
                    err_addr <= 1'b0;
                    busy     <= 1'b0;
                    credit   <= credit - WGHT_W'(1);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BUS_WRR_SCHED_STATS_EN
    logic [15:0] cnt [DRVRS];

    // Counted per source during the PUSH cycle; dropped packets leave push at zero.
    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            for (int i = 0; i < DRVRS; i++) cnt[i] <= '0;
        end else if (state == PUSH && bus.push != '0 && cnt[owner] != 16'hFFFF) begin
            cnt[owner] <= cnt[owner] + 16'd1;
        end
    end

    for (genvar g = 0; g < DRVRS; g++) begin : g_stat
        assign stat_cnt[g*16 +: 16] = cnt[g];
    end
`endif
endmodule
